// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_if
// Purpose  : Valid/ready beat bus carrying LANES instruction/PC pairs.
//            master drives the beat and samples ready; slave does the reverse.
// Signals  : valid     beat valid
//            ready     receiver can take the beat
//            lane_vld  per-lane valid within the beat
//            ins       lane i at [i*INS_W +: INS_W]
//            pc        lane i at [i*PC_W  +: PC_W]
// Revision : 1.0  initial release
// ============================================================================
interface pipe_stage_skid_if #(
   parameter int LANES = 1,
   parameter int INS_W = 32,
   parameter int PC_W  = 32
);
   logic                   valid;
   logic                   ready;
   logic [LANES-1:0]       lane_vld;
   logic [LANES*INS_W-1:0] ins;
   logic [LANES*PC_W-1:0]  pc;

   modport master (output valid, output lane_vld, output ins, output pc, input ready);
   modport slave  (input valid, input lane_vld, input ins, input pc, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Elastic pipeline stage with a 2-entry skid buffer. Carries LANES
//            instruction/PC pairs per beat; in_ready is registered. Supports
//            hold (freeze) and flush (bubble insert). Empty slots show NOP/PC 0.
// Ports    : clk        rising-edge clock
//            rstn       asynchronous active-low reset
//            flush      drop every buffered beat, bubble next cycle
//            hold       freeze: no accept, no pop, registers keep value
//            in_bus     upstream beat (slave side; ready is registered)
//            out_bus    downstream beat (master side)
//            stall_cnt  saturating count of cycles out valid but not taken
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
   parameter int                LANES = 1,   // 1..4
   parameter int                INS_W = 32,
   parameter int                PC_W  = 32,
   parameter logic [INS_W-1:0]  NOP   = INS_W'(32'h0000_0013),
   parameter int                CNT_W = 16
) (
   input  wire logic             clk,
   input  wire logic             rstn,
   input  wire logic             flush,
   input  wire logic             hold,
   pipe_stage_skid_if.slave      in_bus,
   pipe_stage_skid_if.master     out_bus,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [LANES*INS_W-1:0] c_BUB_INS   = {LANES{NOP}};
   localparam logic [LANES*PC_W-1:0]  c_BUB_PC    = '0;
   localparam logic [LANES-1:0]       c_BUB_VLD   = '0;
   localparam logic [CNT_W-1:0]       c_STALL_MAX = {CNT_W{1'b1}};

   // EMPTY: nothing held; ONE: main holds a beat; FULL: main and skid hold beats
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_nxt_state;
   logic                   r_in_ready;

   logic [LANES-1:0]       r_main_vld;
   logic [LANES*INS_W-1:0] r_main_ins;
   logic [LANES*PC_W-1:0]  r_main_pc;
   logic [LANES-1:0]       r_skid_vld;
   logic [LANES*INS_W-1:0] r_skid_ins;
   logic [LANES*PC_W-1:0]  r_skid_pc;
   logic [CNT_W-1:0]       r_stall_cnt;

   logic [LANES*INS_W-1:0] w_in_ins;
   logic [LANES*PC_W-1:0]  w_in_pc;
   logic                   w_out_valid;
   logic                   w_accept;
   logic                   w_pop;
   logic                   w_main_ld_in;
   logic                   w_main_ld_skid;
   logic                   w_main_clr;
   logic                   w_skid_ld_in;
   logic                   w_skid_clr;

   // Invalid lanes are normalised on entry so later stages never see stale data
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_in_ins[gi*INS_W +: INS_W] = in_bus.lane_vld[gi] ? in_bus.ins[gi*INS_W +: INS_W] : NOP;
      assign w_in_pc[gi*PC_W +: PC_W]    = in_bus.lane_vld[gi] ? in_bus.pc[gi*PC_W +: PC_W]    : '0;
   end

   assign w_out_valid = (r_state != S_EMPTY);
   assign w_accept    = in_bus.valid & r_in_ready & ~hold & ~flush;
   assign w_pop       = w_out_valid & out_bus.ready & ~hold;

   always_comb begin
      w_nxt_state    = r_state;
      w_main_ld_in   = 1'b0;
      w_main_ld_skid = 1'b0;
      w_main_clr     = 1'b0;
      w_skid_ld_in   = 1'b0;
      w_skid_clr     = 1'b0;
      if (flush) begin
         // flush overrides hold; a pop in this cycle still counts as delivered
         w_nxt_state = S_EMPTY;
         w_main_clr  = 1'b1;
         w_skid_clr  = 1'b1;
      end else if (!hold) begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  w_nxt_state  = S_ONE;
                  w_main_ld_in = 1'b1;
               end
            end
            S_ONE: begin
               if (w_accept && w_pop) begin
                  w_main_ld_in = 1'b1;
               end else if (w_accept) begin
                  w_nxt_state  = S_FULL;
                  w_skid_ld_in = 1'b1;
               end else if (w_pop) begin
                  w_nxt_state = S_EMPTY;
                  w_main_clr  = 1'b1;
               end
            end
            S_FULL: begin
               // in_ready is low here, so only a pop can change anything
               if (w_pop) begin
                  w_nxt_state    = S_ONE;
                  w_main_ld_skid = 1'b1;
                  w_skid_clr     = 1'b1;
               end
            end
            default: begin
               w_nxt_state = S_EMPTY;
               w_main_clr  = 1'b1;
               w_skid_clr  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_EMPTY;
         r_in_ready <= 1'b1;
         r_main_vld <= c_BUB_VLD;
         r_main_ins <= c_BUB_INS;
         r_main_pc  <= c_BUB_PC;
         r_skid_vld <= c_BUB_VLD;
         r_skid_ins <= c_BUB_INS;
         r_skid_pc  <= c_BUB_PC;
      end else begin
         r_state    <= w_nxt_state;
         // under hold the next state equals the current one, so ready is kept
         r_in_ready <= (w_nxt_state != S_FULL);

         if (w_main_clr) begin
            r_main_vld <= c_BUB_VLD;
            r_main_ins <= c_BUB_INS;
            r_main_pc  <= c_BUB_PC;
         end else if (w_main_ld_in) begin
            r_main_vld <= in_bus.lane_vld;
            r_main_ins <= w_in_ins;
            r_main_pc  <= w_in_pc;
         end else if (w_main_ld_skid) begin
            r_main_vld <= r_skid_vld;
            r_main_ins <= r_skid_ins;
            r_main_pc  <= r_skid_pc;
         end

         if (w_skid_clr) begin
            r_skid_vld <= c_BUB_VLD;
            r_skid_ins <= c_BUB_INS;
            r_skid_pc  <= c_BUB_PC;
         end else if (w_skid_ld_in) begin
            r_skid_vld <= in_bus.lane_vld;
            r_skid_ins <= w_in_ins;
            r_skid_pc  <= w_in_pc;
         end
      end
   end

   // Back-pressure statistic; flush does not clear it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !out_bus.ready && !hold && (r_stall_cnt != c_STALL_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign in_bus.ready     = r_in_ready;
   assign out_bus.valid    = w_out_valid;
   assign out_bus.lane_vld = r_main_vld;
   assign out_bus.ins      = r_main_ins;
   assign out_bus.pc       = r_main_pc;
   assign stall_cnt        = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Self-checking bench for pipe_stage_skid. Instance 1 (LANES=1,
//            CNT_W=4) is compared every cycle against a queue model; instance 2
//            (LANES=2) covers lane masking with literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rstn;
   logic hold1, flush1;
   logic hold2, flush2;
   logic [3:0]  stall1;
   logic [15:0] stall2;

   int n_chk = 0;
   int n_err = 0;

   pipe_stage_skid_if #(.LANES(1)) in1 ();
   pipe_stage_skid_if #(.LANES(1)) out1 ();
   pipe_stage_skid_if #(.LANES(2)) in2 ();
   pipe_stage_skid_if #(.LANES(2)) out2 ();

   pipe_stage_skid #(.LANES(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rstn(rstn), .flush(flush1), .hold(hold1),
      .in_bus(in1), .out_bus(out1), .stall_cnt(stall1)
   );

   pipe_stage_skid #(.LANES(2), .CNT_W(16)) u_dut2 (
      .clk(clk), .rstn(rstn), .flush(flush2), .hold(hold2),
      .in_bus(in2), .out_bus(out2), .stall_cnt(stall2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of instance 1: a FIFO of depth 2 ----
   typedef struct packed {
      logic        vld;
      logic [31:0] ins;
      logic [31:0] pc;
   } beat_t;

   beat_t       mq[$];
   int          m_stall = 0;
   bit          m_valid;
   bit          m_rdy;
   beat_t       m_new;
   beat_t       m_front;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mq.delete();
         m_stall = 0;
      end else begin
         m_valid = (mq.size() != 0);
         m_rdy   = (mq.size() < 2);
         if (m_valid && !out1.ready && !hold1 && m_stall < 15) m_stall++;
         if (flush1) begin
            mq.delete();
         end else if (!hold1) begin
            if (m_valid && out1.ready) void'(mq.pop_front());
            if (in1.valid && m_rdy) begin
               m_new.vld = in1.lane_vld[0];
               m_new.ins = in1.lane_vld[0] ? in1.ins : NOP;
               m_new.pc  = in1.lane_vld[0] ? in1.pc  : 32'h0;
               mq.push_back(m_new);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mq.size() != 0) m_front = mq[0];
      else begin
         m_front.vld = 1'b0;
         m_front.ins = NOP;
         m_front.pc  = 32'h0;
      end
      check("mdl_out_valid", 64'(out1.valid),    64'(mq.size() != 0));
      check("mdl_lane_vld",  64'(out1.lane_vld), 64'(m_front.vld));
      check("mdl_out_ins",   64'(out1.ins),      64'(m_front.ins));
      check("mdl_out_pc",    64'(out1.pc),       64'(m_front.pc));
      check("mdl_in_ready",  64'(in1.ready),     64'(mq.size() < 2));
      check("mdl_stall_cnt", 64'(stall1),        64'(m_stall));
   end

   // ---------------- stimulus helpers ----------------
   task automatic drv(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit lv, input bit ordy, input bit h, input bit f);
      in1.valid    = v;
      in1.ins      = ins;
      in1.pc       = pc;
      in1.lane_vld = lv;
      out1.ready   = ordy;
      hold1        = h;
      flush1       = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rstn = 1'b0;
      drv(0, 32'h0, 32'h0, 0, 0, 0, 0);
      hold2 = 1'b0; flush2 = 1'b0;
      in2.valid = 1'b0; in2.lane_vld = '0; in2.ins = '0; in2.pc = '0; out2.ready = 1'b0;
      tick(); tick();

      // reset state
      check("rst_out_valid", 64'(out1.valid), 64'd0);
      check("rst_out_ins",   64'(out1.ins),   64'h13);
      check("rst_out_pc",    64'(out1.pc),    64'd0);
      check("rst_in_ready",  64'(in1.ready),  64'd1);
      check("rst_stall",     64'(stall1),     64'd0);
      check("rst2_out_ins",  64'(out2.ins),   64'h0000_0013_0000_0013);
      rstn = 1'b1;
      tick();

      // dual-lane masking on instance 2: lane0 invalid, lane1 valid
      in2.valid    = 1'b1;
      in2.lane_vld = 2'b10;
      in2.ins      = {32'h0050_0093, 32'hDEAD_BEEF};
      in2.pc       = {32'h0000_2004, 32'h0000_2000};
      tick();
      check("ln_out_valid", 64'(out2.valid),    64'd1);
      check("ln_lane_vld",  64'(out2.lane_vld), 64'd2);
      check("ln_ins",       64'(out2.ins),      64'h0050_0093_0000_0013);
      check("ln_pc",        64'(out2.pc),       64'h0000_2004_0000_0000);
      in2.valid  = 1'b0;
      out2.ready = 1'b1;
      tick();
      check("ln_drained",   64'(out2.valid),    64'd0);

      // stream 8 beats, output always ready: 1-cycle latency, no stalls
      for (int i = 0; i < 8; i++) begin
         drv(1, 32'h100 + 32'(i), 32'h1000 + 32'(4*i), 1, 1, 0, 0);
         tick();
         check("str_ins",   64'(out1.ins),  64'(32'h100 + 32'(i)));
         check("str_pc",    64'(out1.pc),   64'(32'h1000 + 32'(4*i)));
         check("str_ready", 64'(in1.ready), 64'd1);
      end
      check("str_stall", 64'(stall1), 64'd0);

      // all-bubble beat: lane invalid, garbage data must not leak
      drv(1, 32'hFFFF_FFFF, 32'h55, 0, 1, 0, 0);
      tick();
      check("bub_valid", 64'(out1.valid),    64'd1);
      check("bub_lane",  64'(out1.lane_vld), 64'd0);
      check("bub_ins",   64'(out1.ins),      64'h13);
      check("bub_pc",    64'(out1.pc),       64'd0);
      drv(0, 32'h0, 32'h0, 0, 1, 0, 0);
      tick();
      check("bub_popped", 64'(out1.valid), 64'd0);

      // A, B with downstream stalled -> FULL, then drain in order
      drv(1, 32'hA0, 32'hA00, 1, 0, 0, 0);
      tick();
      drv(1, 32'hB0, 32'hB04, 1, 0, 0, 0);
      tick();
      check("full_ready", 64'(in1.ready), 64'd0);
      check("full_ins",   64'(out1.ins),  64'hA0);
      check("full_stall", 64'(stall1),    64'd1);
      drv(0, 32'h0, 32'h0, 0, 1, 0, 0);
      tick();
      check("pop1_ins",   64'(out1.ins),  64'hB0);
      check("pop1_ready", 64'(in1.ready), 64'd1);
      tick();
      check("pop2_valid", 64'(out1.valid), 64'd0);

      // FULL then flush with C presented: C is discarded
      drv(1, 32'hA1, 32'hA10, 1, 0, 0, 0);
      tick();
      drv(1, 32'hB1, 32'hB14, 1, 0, 0, 0);
      tick();
      check("fl_full", 64'(in1.ready), 64'd0);
      drv(1, 32'hC0, 32'hC00, 1, 0, 0, 1);
      tick();
      check("fl_valid", 64'(out1.valid), 64'd0);
      check("fl_ins",   64'(out1.ins),   64'h13);
      check("fl_pc",    64'(out1.pc),    64'd0);
      check("fl_ready", 64'(in1.ready),  64'd1);
      check("fl_stall", 64'(stall1),     64'd3);
      drv(0, 32'h0, 32'h0, 0, 1, 0, 0);
      tick(); tick();
      check("fl_no_c", 64'(out1.valid), 64'd0);

      // hold for 3 cycles: everything frozen even with traffic on both sides
      drv(1, 32'hD0, 32'hD00, 1, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drv(1, 32'hE0, 32'hE00, 1, 1, 1, 0);
         tick();
         check("hold_ins",   64'(out1.ins),   64'hD0);
         check("hold_valid", 64'(out1.valid), 64'd1);
         check("hold_stall", 64'(stall1),     64'd3);
      end
      drv(1, 32'hE0, 32'hE00, 1, 1, 1, 1);
      tick();
      check("hfl_valid", 64'(out1.valid), 64'd0);
      check("hfl_ins",   64'(out1.ins),   64'h13);
      drv(0, 32'h0, 32'h0, 0, 1, 0, 0);
      tick();

      // stall counter saturation with CNT_W=4
      drv(1, 32'hF0, 32'hF00, 1, 0, 0, 0);
      tick();
      drv(0, 32'h0, 32'h0, 0, 0, 0, 0);
      repeat (20) tick();
      check("sat_stall", 64'(stall1),    64'd15);
      check("sat_ins",   64'(out1.ins),  64'hF0);

      // asynchronous reset mid-cycle: outputs return before the next edge
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("arst_valid", 64'(out1.valid), 64'd0);
      check("arst_ins",   64'(out1.ins),   64'h13);
      check("arst_ready", 64'(in1.ready),  64'd1);
      check("arst_stall", 64'(stall1),     64'd0);
      #2;
      rstn = 1'b1;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
